uart_recv: RTL and testbench

UART_RECV -- requirements
Module: uart_recv

---
 rtl/uart_recv.sv | 80 ++++++++
 tb/tb_uart_recv.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with mid-bit sampling and one-cycle valid pulse.
// Define UART_RECV_FRAME_ERR_EN to add the frame_err output for bad stop bits.
module uart_recv #(
    parameter int BAUD_MAX = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       valid,
    output logic [7:0] data
`ifdef UART_RECV_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);
    localparam int CW = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
    localparam logic [CW-1:0] FULL = CW'(BAUD_MAX - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_MAX / 2 - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state;
    logic [1:0]      din_sync;
    logic            din_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    assign din_s = din_sync[1];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            din_sync <= 2'b11;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            data     <= '0;
            valid    <= 1'b0;
`ifdef UART_RECV_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            din_sync <= {din_sync[0], din};
            valid    <= 1'b0;
`ifdef UART_RECV_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            cnt <= cnt + CW'(1);
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!din_s) state <= START;
                end
                START: if (cnt == HALF) begin
                    cnt   <= '0;
                    state <= din_s ? IDLE : DATA;
                end
                DATA: if (cnt == FULL) begin
                    cnt            <= '0;
                    shift[bit_cnt] <= din_s;
                    bit_cnt        <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end
                STOP: if (cnt == FULL) begin
                    // Leave at mid stop bit so a back-to-back start edge is caught
                    cnt   <= '0;
                    state <= IDLE;
                    if (din_s) begin
                        data  <= shift;
                        valid <= 1'b1;
                    end
`ifdef UART_RECV_FRAME_ERR_EN
                    else frame_err <= 1'b1;
`endif
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed scoreboard bench for uart_recv; a 16-cycle bit period
// keeps every scenario, including the +-3 cycle edge skew, short to simulate.
module tb_uart_recv;
    localparam int BAUD = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b1;
    logic       valid;
    logic [7:0] data;
`ifdef UART_RECV_FRAME_ERR_EN
    logic       frame_err;
    int         nfe = 0;
`endif
    int         checks = 0;
    int         errors = 0;
    int         nvalid = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         last_lat = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q[$];

    uart_recv #(.BAUD_MAX(BAUD)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .valid(valid),
        .data(data)
`ifdef UART_RECV_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every valid pulse and guards data stability
    always @(negedge clk) begin
        if (rst) begin
            if (valid) begin
                nvalid++;
                last_lat = cyc - t_start;
                if (exp_q.size() == 0) check("unexpected_valid", data, 32'hffff_ffff);
                else check("data", data, exp_q.pop_front());
                if (prev_valid) check("valid_width", 2, 1);
            end else check("data_hold", data, prev_data);
`ifdef UART_RECV_FRAME_ERR_EN
            if (frame_err) nfe++;
`endif
        end
        prev_valid = valid;
        prev_data  = data;
    end

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame; skew jitters interior edges, cut aborts after that many cycles
    task automatic send(input logic [7:0] b, input logic stop, input int skew, input int cut);
        int   bnd[11];
        logic lvl[10];
        lvl[0] = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i+1] = b[i];
        lvl[9] = stop;
        bnd[0]  = 0;
        bnd[10] = 10 * BAUD;
        for (int k = 1; k < 10; k++)
            bnd[k] = k * BAUD + (skew > 0 ? int'($urandom_range(2 * skew)) - skew : 0);
        t_start = cyc;
        for (int k = 0; k < 10; k++) begin
            din = lvl[k];
            for (int c = bnd[k]; c < bnd[k+1]; c++) begin
                if (cut > 0 && c >= cut) return;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $error("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        repeat (3) @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_data", data, 8'h00);
        rst = 1'b1;
        idle(5);
        // Single frame: latency is 9.5 bits plus 2-flop sync and output register
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, 0, 0);
        idle(10);
        check("frame55_count", nvalid, 1);
        check("frame55_latency", last_lat, 9 * BAUD + BAUD / 2 + 3);
        check("frame55_data", data, 8'h55);
        // Back-to-back frames with no idle gap
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'hA3, 1'b1, 0, 0);
        send(8'h00, 1'b1, 0, 0);
        send(8'hFF, 1'b1, 0, 0);
        idle(10);
        check("b2b_count", nvalid, 4);
        check("b2b_queue", exp_q.size(), 0);
        // Glitch shorter than half a bit
        din = 1'b0;
        repeat (BAUD / 2 - 3) @(negedge clk);
        idle(3 * BAUD);
        check("glitch_count", nvalid, 4);
        check("glitch_data", data, 8'hFF);
        // Bad stop bit
        send(8'h3C, 1'b0, 0, 0);
        idle(3 * BAUD);
        check("badstop_count", nvalid, 4);
        check("badstop_data", data, 8'hFF);
`ifdef UART_RECV_FRAME_ERR_EN
        check("badstop_frame_err", nfe, 1);
`endif
        // Reset in the middle of data bit 4 of 0x96
        nv = nvalid;
        send(8'h96, 1'b1, 0, 5 * BAUD + BAUD / 2);
        rst = 1'b0;
        #1;
        check("async_reset_data", data, 8'h00);
        check("async_reset_valid", valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(3 * BAUD);
        check("reset_abort_count", nvalid, nv);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1, 0, 0);
        idle(10);
        check("after_reset_count", nvalid, nv + 1);
        check("after_reset_data", data, 8'h81);
        // Skewed line edges
        exp_q.push_back(8'hC5);
        send(8'hC5, 1'b1, 3, 0);
        idle(10);
        check("skew_count", nvalid, nv + 2);
        check("skew_data", data, 8'hC5);
        check("final_queue", exp_q.size(), 0);
`ifdef UART_RECV_FRAME_ERR_EN
        check("final_frame_err", nfe, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
